emergency_preempt_ctrl: RTL and testbench

//  Sequences emergency-vehicle preemption for the 4-approach intersection (lanes 2k,2k+1 = approach k).

---
 rtl/emergency_preempt_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_emergency_preempt_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emergency_preempt_ctrl.sv
// Emergency-vehicle preemption sequencer for a 4-approach intersection.
// Clears normal greens through yellow/all-red, serves one requesting approach
// at a time (round-robin), then hands the lamps back to the normal controller.
module emergency_preempt_ctrl #(
    parameter int unsigned YELLOW_TICKS = 3,
    parameter int unsigned ALLRED_TICKS = 2,
    parameter int unsigned HOLD_MIN     = 5,
    parameter int unsigned HOLD_MAX     = 20,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [0:7] emergencyLane,
    input  logic [0:7] normal_green,
    input  logic [0:7] normal_yellow,
    output logic [0:7] lane_green,
    output logic [0:7] lane_yellow,
    output logic [0:3] grant,
    output logic       preempt_active
);

    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_MIN_C  = CNT_W'(HOLD_MIN);
    localparam logic [CNT_W-1:0] HOLD_MAX_C  = CNT_W'(HOLD_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ALLRED,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:7]       mask_q, mask_d;
    logic [1:0]       rr_q, rr_d;
    logic [1:0]       g_q, g_d;
    logic [0:7]       lane_green_q, lane_green_d;
    logic [0:7]       lane_yellow_q, lane_yellow_d;
    logic [0:3]       grant_q, grant_d;
    logic             preempt_q, preempt_d;

    logic [0:3]       req_c;
    logic [0:3]       g_onehot_c;
    logic [0:7]       g_lanes_c;
    logic             any_req_c;
    logic             others_req_c;
    logic [1:0]       pick_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             yellow_done_c;
    logic             allred_done_c;

    // Per-approach request: either lane of the approach asking
    assign req_c[0] = emergencyLane[0] | emergencyLane[1];
    assign req_c[1] = emergencyLane[2] | emergencyLane[3];
    assign req_c[2] = emergencyLane[4] | emergencyLane[5];
    assign req_c[3] = emergencyLane[6] | emergencyLane[7];

    assign any_req_c     = |req_c;
    assign cnt_inc_c     = cnt_q + CNT_W'(1);
    assign yellow_done_c = tick && (cnt_q == YELLOW_LAST);
    assign allred_done_c = tick && (cnt_q == ALLRED_LAST);

    // Decode the granted approach into a one-hot grant and its lane pair
    always_comb begin
        g_onehot_c                = '0;
        g_onehot_c[g_q]           = 1'b1;
        g_lanes_c                 = '0;
        g_lanes_c[{g_q, 1'b0}]    = 1'b1;
        g_lanes_c[{g_q, 1'b1}]    = 1'b1;
    end

    assign others_req_c = |(req_c & ~g_onehot_c);

    // Round-robin pick: first requesting approach at or after rr_q
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found  = 1'b0;
        idx    = rr_q;
        pick_c = rr_q;
        for (int i = 0; i < 4; i++) begin
            idx = rr_q + 2'(i);
            if (!found && req_c[idx]) begin
                found  = 1'b1;
                pick_c = idx;
            end
        end
    end

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mask_d        = mask_q;
        rr_d          = rr_q;
        g_d           = g_q;
        lane_green_d  = '0;
        lane_yellow_d = '0;
        grant_d       = '0;
        preempt_d     = 1'b1;

        case (state_q)
            S_IDLE: begin
                lane_green_d  = normal_green;
                lane_yellow_d = normal_yellow;
                preempt_d     = 1'b0;
                cnt_d         = '0;
                if (any_req_c) begin
                    mask_d  = normal_green | normal_yellow;
                    state_d = (|(normal_green | normal_yellow)) ? S_CLEAR : S_ALLRED;
                end
            end

            S_CLEAR: begin
                lane_yellow_d = mask_q;
                if (tick) cnt_d = cnt_inc_c;
                if (yellow_done_c) begin
                    state_d = S_ALLRED;
                    cnt_d   = '0;
                end
            end

            S_ALLRED: begin
                if (tick) cnt_d = cnt_inc_c;
                if (allred_done_c) begin
                    cnt_d = '0;
                    if (any_req_c) begin
                        g_d     = pick_c;
                        rr_d    = pick_c + 2'd1;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_HOLD: begin
                lane_green_d = g_lanes_c;
                grant_d      = g_onehot_c;
                // Saturate so a long hold cannot wrap below HOLD_MAX
                if (tick && (cnt_q < HOLD_MAX_C)) cnt_d = cnt_inc_c;
                if ((!req_c[g_q] && (cnt_q >= HOLD_MIN_C)) ||
                    (others_req_c && (cnt_q >= HOLD_MAX_C))) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end
            end

            S_RELEASE: begin
                lane_yellow_d = g_lanes_c;
                grant_d       = g_onehot_c;
                if (tick) cnt_d = cnt_inc_c;
                if (yellow_done_c) begin
                    state_d = S_ALLRED;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any sequence without clearance
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            mask_q        <= '0;
            rr_q          <= '0;
            g_q           <= '0;
            lane_green_q  <= '0;
            lane_yellow_q <= '0;
            grant_q       <= '0;
            preempt_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            rr_q          <= rr_d;
            g_q           <= g_d;
            lane_green_q  <= lane_green_d;
            lane_yellow_q <= lane_yellow_d;
            grant_q       <= grant_d;
            preempt_q     <= preempt_d;
        end
    end

    assign lane_green     = lane_green_q;
    assign lane_yellow    = lane_yellow_q;
    assign grant          = grant_q;
    assign preempt_active = preempt_q;

endmodule

// File: tb/tb_emergency_preempt_ctrl.sv
// Self-checking bench for emergency_preempt_ctrl: table-driven idle pass-through
// vectors plus hand-written preemption sequences checked as lamp segments.
module tb_emergency_preempt_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [0:7] emergency_lane = '0;
    logic [0:7] normal_green = '0;
    logic [0:7] normal_yellow = '0;
    logic [0:7] lane_green;
    logic [0:7] lane_yellow;
    logic [0:3] grant;
    logic       preempt_active;

    int   errors = 0;
    int   checks = 0;
    int   tdiv = 0;
    int   green_viol = 0;
    logic last_tick = 1'b0;

    emergency_preempt_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .emergencyLane  (emergency_lane),
        .normal_green   (normal_green),
        .normal_yellow  (normal_yellow),
        .lane_green     (lane_green),
        .lane_yellow    (lane_yellow),
        .grant          (grant),
        .preempt_active (preempt_active)
    );

    always #5 clk = ~clk;

    // One run of constant preemption lamps, with the number of ticks it lasted
    typedef struct {
        logic [0:7] g;
        logic [0:7] y;
        logic [0:3] gr;
        int         ticks;
    } seg_t;

    typedef struct {
        logic [0:7] ng;
        logic [0:7] ny;
        logic [0:7] eg;
        logic [0:7] ey;
    } vec_t;

    seg_t seg_q[$];
    seg_t exp_q[$];
    vec_t vecs[6];

    // Outputs seen in a cycle reflect the state of the previous cycle, so they
    // are paired with the tick of the previous cycle.
    always @(negedge clk) begin : mon
        logic t;
        int   n;
        int   napp;
        seg_t s;
        t = last_tick;
        last_tick = tick;
        napp = 0;
        for (int k = 0; k < 4; k++)
            if (lane_green[2*k] || lane_green[2*k+1]) napp++;
        if (preempt_active && napp > 1) green_viol++;
        if (preempt_active && !rst) begin
            n = seg_q.size();
            if (n == 0 || seg_q[n-1].g != lane_green || seg_q[n-1].y != lane_yellow ||
                seg_q[n-1].gr != grant) begin
                s.g     = lane_green;
                s.y     = lane_yellow;
                s.gr    = grant;
                s.ticks = t ? 1 : 0;
                seg_q.push_back(s);
            end else begin
                seg_q[n-1].ticks = seg_q[n-1].ticks + (t ? 1 : 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        tdiv = (tdiv + 1) % 4;
        tick = (tdiv == 0);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        emergency_lane = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        seg_q.delete();
    endtask

    task automatic add_exp(input logic [0:7] g, input logic [0:7] y, input logic [0:3] gr,
                           input int ticks);
        seg_t s;
        s.g = g; s.y = y; s.gr = gr; s.ticks = ticks;
        exp_q.push_back(s);
    endtask

    task automatic cmp_segs(input string tname);
        chk({tname, " seg_count"}, 64'(seg_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < seg_q.size(); i++) begin
            chk($sformatf("%s seg%0d lamps", tname, i),
                64'({seg_q[i].g, seg_q[i].y, seg_q[i].gr}),
                64'({exp_q[i].g, exp_q[i].y, exp_q[i].gr}));
            chk($sformatf("%s seg%0d ticks", tname, i),
                64'(seg_q[i].ticks), 64'(exp_q[i].ticks));
        end
        exp_q.delete();
    endtask

    // Wait until segment nseg-1 exists and has at least min_ticks ticks
    task automatic wait_segs(input string tname, input int nseg, input int min_ticks);
        int timed_out;
        timed_out = 1;
        for (int c = 0; c < 2000; c++) begin
            if (seg_q.size() >= nseg && seg_q[nseg-1].ticks >= min_ticks) begin
                timed_out = 0;
                break;
            end
            step();
        end
        chk({tname, " reach segment"}, 64'(timed_out), 64'(0));
    endtask

    // Wait for the preemption sequence to end and settle in IDLE
    task automatic wait_idle(input string tname);
        int timed_out;
        timed_out = 1;
        for (int c = 0; c < 2000; c++) begin
            step();
            if (!preempt_active) begin
                timed_out = 0;
                break;
            end
        end
        step();
        step();
        chk({tname, " back to idle"}, 64'(timed_out), 64'(0));
    endtask

    initial begin
        vecs[0] = '{8'hC0, 8'h00, 8'hC0, 8'h00};
        vecs[1] = '{8'h00, 8'h30, 8'h00, 8'h30};
        vecs[2] = '{8'h0C, 8'h03, 8'h0C, 8'h03};
        vecs[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{8'h33, 8'hCC, 8'h33, 8'hCC};

        // Reset state and idle pass-through
        normal_green = 8'hFF;
        normal_yellow = 8'hFF;
        do_reset();
        chk("reset_state", 64'({lane_green, lane_yellow, grant, preempt_active}), 64'(0));
        for (int i = 0; i < 6; i++) begin
            normal_green = vecs[i].ng;
            normal_yellow = vecs[i].ny;
            step();
            chk($sformatf("idle_pass vec%0d", i),
                64'({lane_green, lane_yellow, grant, preempt_active}),
                64'({vecs[i].eg, vecs[i].ey, 4'b0000, 1'b0}));
        end

        // Reset in HOLD aborts with no clearance; normal lamps return one clock later
        normal_green = 8'h30;
        normal_yellow = 8'h00;
        do_reset();
        emergency_lane = 8'b1000_0000;
        wait_segs("rst_hold", 3, 0);
        chk("rst_hold in hold", 64'({lane_green, grant}), 64'({8'hC0, 4'b1000}));
        rst = 1'b1;
        step();
        chk("rst_hold first clk", 64'({lane_green, lane_yellow, grant, preempt_active}), 64'(0));
        step();
        step();
        emergency_lane = '0;
        chk("rst_hold held", 64'({lane_green, lane_yellow, grant, preempt_active}), 64'(0));
        rst = 1'b0;
        step();
        chk("rst_hold release", 64'({lane_green, lane_yellow, grant, preempt_active}),
            64'({8'h30, 8'h00, 4'b0000, 1'b0}));
        seg_q.delete();

        // Approach 2 request over a normal green on approach 0
        normal_green = 8'hC0;
        normal_yellow = 8'h00;
        do_reset();
        emergency_lane = 8'b0000_0100;
        wait_segs("basic", 3, 8);
        emergency_lane = '0;
        wait_idle("basic");
        add_exp(8'h00, 8'hC0, 4'b0000, 3);
        add_exp(8'h00, 8'h00, 4'b0000, 2);
        add_exp(8'h0C, 8'h00, 4'b0010, 8);
        add_exp(8'h00, 8'h0C, 4'b0010, 3);
        add_exp(8'h00, 8'h00, 4'b0000, 2);
        cmp_segs("basic");
        chk("basic idle lamps", 64'({lane_green, lane_yellow, preempt_active}),
            64'({8'hC0, 8'h00, 1'b0}));

        // Request dropped early in HOLD still gets HOLD_MIN of green
        normal_green = 8'h00;
        normal_yellow = 8'h03;
        do_reset();
        emergency_lane = 8'b1000_0000;
        wait_segs("hold_min", 3, 1);
        emergency_lane = '0;
        wait_idle("hold_min");
        add_exp(8'h00, 8'h03, 4'b0000, 3);
        add_exp(8'h00, 8'h00, 4'b0000, 2);
        add_exp(8'hC0, 8'h00, 4'b1000, 5);
        add_exp(8'h00, 8'hC0, 4'b1000, 3);
        add_exp(8'h00, 8'h00, 4'b0000, 2);
        cmp_segs("hold_min");

        // Approaches 0 and 2 both pending: HOLD_MAX yield and round-robin
        normal_green = 8'h00;
        normal_yellow = 8'h00;
        do_reset();
        emergency_lane = 8'b1000_1000;
        wait_segs("rr", 8, 0);
        emergency_lane = '0;
        wait_idle("rr");
        add_exp(8'h00, 8'h00, 4'b0000, 2);
        add_exp(8'hC0, 8'h00, 4'b1000, 20);
        add_exp(8'h00, 8'hC0, 4'b1000, 3);
        add_exp(8'h00, 8'h00, 4'b0000, 2);
        add_exp(8'h0C, 8'h00, 4'b0010, 20);
        add_exp(8'h00, 8'h0C, 4'b0010, 3);
        add_exp(8'h00, 8'h00, 4'b0000, 2);
        add_exp(8'hC0, 8'h00, 4'b1000, 5);
        add_exp(8'h00, 8'hC0, 4'b1000, 3);
        add_exp(8'h00, 8'h00, 4'b0000, 2);
        cmp_segs("rr");

        // Normal all-red: CLEAR skipped, straight to all-red then approach 3
        normal_green = 8'h00;
        normal_yellow = 8'h00;
        do_reset();
        emergency_lane = 8'b0000_0001;
        wait_segs("no_mask", 2, 0);
        emergency_lane = '0;
        wait_idle("no_mask");
        add_exp(8'h00, 8'h00, 4'b0000, 2);
        add_exp(8'h03, 8'h00, 4'b0001, 5);
        add_exp(8'h00, 8'h03, 4'b0001, 3);
        add_exp(8'h00, 8'h00, 4'b0000, 2);
        cmp_segs("no_mask");

        // Request vanishes during CLEAR: clearance completes, no grant
        normal_green = 8'h30;
        normal_yellow = 8'h00;
        do_reset();
        emergency_lane = 8'b0010_0000;
        step();
        step();
        emergency_lane = '0;
        wait_idle("drop_clear");
        add_exp(8'h00, 8'h30, 4'b0000, 3);
        add_exp(8'h00, 8'h00, 4'b0000, 2);
        cmp_segs("drop_clear");
        chk("drop_clear idle lamps", 64'({lane_green, lane_yellow, grant, preempt_active}),
            64'({8'h30, 8'h00, 4'b0000, 1'b0}));

        chk("no_dual_green", 64'(green_viol), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
